mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Parametrised load/store unit between the datapath and a word-wide data memory port.
//  Generalises in-datapath byte/half load muxing: any size up to XLEN, signed/unsigned loads,
//  byte-enabled stores, optional misaligned split accesses, and ack timeout.
//  Sits between ALU result/regfile write data and data memory; datapath stalls on req_ready/rsp_valid.
// PARAMETERS
//  XLEN            32  data/word width, 32 or 64; NB = XLEN/8 bytes per word
//  ALLOW_MISALIGN  1   1: word-crossing access split into two memory cycles; 0: flagged as error
//  TIMEOUT         16  max cycles mem_req may wait for mem_ack before abort; 0 = no timeout
// PORTS
//  clk        in   1         clock, rising edge
//  reset      in   1         asynchronous, active-low reset
//  req_valid  in   1         request present
//  req_ready  out  1         unit can accept request (IDLE only)
//  req_write  in   1         1 store, 0 load
//  req_size   in   2         log2 bytes: 0 byte, 1 half, 2 word, 3 dword (XLEN=64 only)
//  req_unsigned in 1         load zero-extends when 1, sign-extends when 0
//  req_addr   in   32        byte address
//  req_wdata  in   XLEN      store data, right-justified
//  rsp_valid  out  1         response available
//  rsp_ready  in   1         consumer takes response
//  rsp_rdata  out  XLEN      extended load data; 0 for stores and errors
//  rsp_err    out  1         misaligned (ALLOW_MISALIGN=0), bad size, or timeout
//  mem_req    out  1         memory access request
//  mem_we     out  1         memory write
//  mem_addr   out  32        word-aligned address (low log2(NB) bits 0)
//  mem_be     out  NB        byte enables (writes; all-ones on reads)
//  mem_wdata  out  XLEN      lane-aligned store data
//  mem_ack    in   1         memory done; may be asserted in the same cycle as mem_req
//  mem_rdata  in   XLEN      read word, valid when mem_ack
// BEHAVIOUR
//  - reset low: state IDLE, all outputs 0 (incl. req_ready), counters/latches cleared, any
//    in-flight access abandoned with no response; mem_req drops asynchronously.
//  - FSM IDLE->ACC0->[ACC1]->RESP->IDLE. IDLE: req_ready=1; valid&ready latches all req_* fields.
//  - Accept: off=addr mod NB, n=1<<size. span = off+n > NB. Size 3 with XLEN=32, or span with
//    ALLOW_MISALIGN=0 -> RESP directly, rsp_err=1, no memory access.
//  - ACC0: mem_req=1, mem_addr=addr&~(NB-1); ACC1: mem_addr=that+NB. Outputs held stable until
//    mem_ack; on ack, capture mem_rdata to word0/word1 and advance (ACC0->ACC1 if span, else RESP).
//  - Store: wide = wdata<<(8*off) over 2*XLEN; be2 = ((1<<n)-1)<<off over 2*NB.
//    ACC0 uses low halves, ACC1 high halves. Loads: mem_we=0, mem_be all-ones.
//  - Load: v = ({word1,word0} >> 8*off)[8n-1:0]; sign- or zero-extended to XLEN.
//  - Timeout: counter clears on entering ACC0/ACC1, increments each cycle mem_req=1 and
//    mem_ack=0; reaching TIMEOUT -> RESP, rsp_err=1, rsp_rdata=0. A store whose ACC0 was acked
//    but ACC1 timed out leaves memory partially written (documented, not rolled back).
//  - RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready; rsp_valid&rsp_ready -> IDLE.
//    No new request accepted in the same cycle (req_ready=0 outside IDLE).
//  - Latency, zero-wait memory: accept at T; ACC0 at T+1 (ack same cycle); rsp_valid at T+2.
//    Split access adds 1 cycle. Error without access: rsp_valid at T+1.
// TESTING
//  1 aligned LW addr 0x100, mem word 0xDEADBEEF, ack same cycle -> mem_addr 0x100, rsp_rdata
//    0xDEADBEEF, rsp_err 0, rsp_valid 2 cycles after accept
//  2 LB/LBU addr 0x103, word 0x80FF7F01 -> LB rsp 0xFFFFFF80, LBU rsp 0x00000080
//  3 SH addr 0x102 wdata 0x0000ABCD -> one access, mem_be 4'b1100, mem_wdata 0xABCD0000
//  4 misaligned LW addr 0x106, words@0x104=0x44332211 @0x108=0x88776655 -> two reqs,
//    rsp 0x66554433; same with ALLOW_MISALIGN=0 -> no mem_req, rsp_err 1
//  5 mem_ack never asserted, TIMEOUT=16 -> mem_req high exactly 16 cycles, then rsp_err 1,
//    rsp_rdata 0; rsp_ready held low 5 cycles -> rsp_valid/data stable throughout
//  6 reset pulled low during ACC1 of split store -> mem_req 0 immediately, no rsp_valid,
//    req_ready 1 in first cycle after reset release

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the datapath and a word-wide data memory port: sub-word and
// misaligned (split) accesses, sign/zero-extended loads, byte-enabled stores, ack timeout.
module mem_access_unit #(
   parameter int XLEN           = 32,
   parameter int ALLOW_MISALIGN = 1,
   parameter int TIMEOUT        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic              rsp_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [XLEN/8-1:0] mem_be,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_ack,
   input  logic [XLEN-1:0]   mem_rdata
);
   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);
   localparam int TW = $clog2(TIMEOUT + 2);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
   state_t state_reg, state_next;

   logic            write_reg, unsigned_reg, span_reg, err_reg;
   logic [1:0]      size_reg;
   logic [31:0]     addr_reg;
   logic [XLEN-1:0] wdata_reg, word0_reg, word1_reg;
   logic [TW-1:0]   cnt_reg;

   logic [OW-1:0]   req_off;
   int              req_n;
   logic            req_span, req_bad, accept;

   assign req_off  = req_addr[OW-1:0];
   assign req_n    = 1 << req_size;
   assign req_span = (int'(req_off) + req_n) > NB;
   assign req_bad  = (req_n > NB) || (req_span && (ALLOW_MISALIGN == 0));
   assign accept   = req_valid && reset && (state_reg == IDLE);

   logic [OW-1:0]   off;
   int              n_bytes, nbits;
   logic            timeout_hit;

   assign off         = addr_reg[OW-1:0];
   assign n_bytes     = 1 << size_reg;
   assign nbits       = 8 * n_bytes;
   assign timeout_hit = (TIMEOUT != 0) && ((int'(cnt_reg) + 1) >= TIMEOUT);

   // Store data and enables laid out over two words; ACC0 drives the low half, ACC1 the high.
   logic [2*XLEN-1:0] wide;
   logic [NB-1:0]     be_base;
   logic [2*NB-1:0]   be_wide;

   assign wide = {{XLEN{1'b0}}, wdata_reg} << {off, 3'b000};
   for (genvar gi = 0; gi < NB; gi++) begin : g_be
      assign be_base[gi] = (gi < n_bytes);
   end
   assign be_wide = {{NB{1'b0}}, be_base} << off;

   logic [XLEN-1:0] pair;
   logic [XLEN-1:0] load_ext;
   logic            sign_bit;

   assign pair = XLEN'({word1_reg, word0_reg} >> {off, 3'b000});
   always_comb begin
      sign_bit = 1'b0;
      for (int i = 0; i < XLEN; i++) begin
         if (i == nbits - 1) sign_bit = pair[i] & ~unsigned_reg;
      end
   end
   for (genvar gi = 0; gi < XLEN; gi++) begin : g_ext
      assign load_ext[gi] = (gi < nbits) ? pair[gi] : sign_bit;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         write_reg    <= 1'b0;
         unsigned_reg <= 1'b0;
         span_reg     <= 1'b0;
         err_reg      <= 1'b0;
         size_reg     <= '0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         word0_reg    <= '0;
         word1_reg    <= '0;
         cnt_reg      <= '0;
      end else if (accept) begin
         write_reg    <= req_write;
         unsigned_reg <= req_unsigned;
         span_reg     <= req_span;
         err_reg      <= req_bad;
         size_reg     <= req_size;
         addr_reg     <= req_addr;
         wdata_reg    <= req_wdata;
         word0_reg    <= '0;
         word1_reg    <= '0;
         cnt_reg      <= '0;
      end else if (state_reg == ACC0 || state_reg == ACC1) begin
         if (mem_ack) begin
            if (state_reg == ACC0) word0_reg <= mem_rdata;
            else                   word1_reg <= mem_rdata;
            cnt_reg <= '0;
         end else if (timeout_hit) begin
            err_reg <= 1'b1;
            cnt_reg <= '0;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      rsp_err    = 1'b0;
      rsp_rdata  = '0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_be     = '0;
      mem_wdata  = '0;
      case (state_reg)
         IDLE: begin
            // Gated by reset so every output reads 0 while reset is held.
            req_ready = reset;
            if (accept) state_next = req_bad ? RESP : ACC0;
         end
         ACC0: begin
            mem_req   = 1'b1;
            mem_we    = write_reg;
            mem_addr  = {addr_reg[31:OW], {OW{1'b0}}};
            mem_be    = write_reg ? be_wide[NB-1:0] : '1;
            mem_wdata = wide[XLEN-1:0];
            if (mem_ack)          state_next = span_reg ? ACC1 : RESP;
            else if (timeout_hit) state_next = RESP;
         end
         ACC1: begin
            mem_req   = 1'b1;
            mem_we    = write_reg;
            mem_addr  = {addr_reg[31:OW], {OW{1'b0}}} + 32'(NB);
            mem_be    = write_reg ? be_wide[2*NB-1:NB] : '1;
            mem_wdata = wide[2*XLEN-1:XLEN];
            if (mem_ack || timeout_hit) state_next = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = err_reg;
            rsp_rdata = (write_reg || err_reg) ? '0 : load_ext;
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: randomized loads/stores against a byte-level memory model,
// scoreboarded responses, plus directed latency, timeout, reset and no-misalign cases.
module tb_mem_access_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   always #5 clk = ~clk;

   logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_unsigned = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
   logic [31:0] rsp_rdata;
   logic        mem_req, mem_we, mem_ack = 1'b0;
   logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'h0;
   logic [3:0]  mem_be;

   logic        na_req_valid = 1'b0, na_req_ready, na_rsp_valid, na_rsp_err;
   logic        na_req_write = 1'b0, na_req_unsigned = 1'b0, na_rsp_ready = 1'b1;
   logic [1:0]  na_req_size = 2'd0;
   logic [31:0] na_req_addr = 32'h0, na_req_wdata = 32'h0, na_rsp_rdata;
   logic        na_mem_req, na_mem_we, na_mem_ack = 1'b1;
   logic [31:0] na_mem_addr, na_mem_wdata, na_mem_rdata = 32'h1234_5678;
   logic [3:0]  na_mem_be;

   mem_access_unit #(.XLEN(32), .ALLOW_MISALIGN(1), .TIMEOUT(16)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata));

   mem_access_unit #(.XLEN(32), .ALLOW_MISALIGN(0), .TIMEOUT(16)) u_dut_na (
      .clk(clk), .reset(reset), .req_valid(na_req_valid), .req_ready(na_req_ready),
      .req_write(na_req_write), .req_size(na_req_size), .req_unsigned(na_req_unsigned),
      .req_addr(na_req_addr), .req_wdata(na_req_wdata), .rsp_valid(na_rsp_valid),
      .rsp_ready(na_rsp_ready), .rsp_rdata(na_rsp_rdata), .rsp_err(na_rsp_err),
      .mem_req(na_mem_req), .mem_we(na_mem_we), .mem_addr(na_mem_addr), .mem_be(na_mem_be),
      .mem_wdata(na_mem_wdata), .mem_ack(na_mem_ack), .mem_rdata(na_mem_rdata));

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   // Reference memory: 64 bytes starting at 0x100, little-endian.
   logic [7:0]  ref_mem [64];
   logic [31:0] phys [16];

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input bit u);
      logic [63:0] v = 64'h0;
      int n = 1 << sz;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(a - 32'h100) + i];
      if (!u && n < 4 && v[8*n-1]) begin
         for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
      end
      return v[31:0];
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd, input int maxb);
      int n = 1 << sz;
      for (int i = 0; i < n && i < maxb; i++) ref_mem[int'(a - 32'h100) + i] = wd[8*i +: 8];
   endtask

   task automatic set_word(input logic [31:0] a, input logic [31:0] val);
      int k = int'(a - 32'h100) / 4;
      phys[k] = val;
      for (int b = 0; b < 4; b++) ref_mem[4*k + b] = val[8*b +: 8];
   endtask

   // Memory responder with random (or zero) ack delay.
   bit          no_ack = 1'b0, zero_wait = 1'b0, pending = 1'b0;
   logic [31:0] block_addr = 32'hFFFF_FFFF;
   int          wait_left = 0, acks = 0, req_run = 0, last_run = 0;
   logic [31:0] last_addr = 0, last_wdata = 0, hold_addr = 0, hold_wdata = 0;
   logic [3:0]  last_be = 0, hold_be = 0;
   logic        last_we = 0, hold_we = 0;

   always @(negedge clk) begin
      if (!reset) begin
         mem_ack = 1'b0;
         pending = 1'b0;
         req_run = 0;
      end else if (mem_req) begin
         req_run++;
         if (!pending) begin
            pending   = 1'b1;
            wait_left = zero_wait ? 0 : int'($urandom_range(0, 3));
            hold_addr = mem_addr; hold_be = mem_be; hold_wdata = mem_wdata; hold_we = mem_we;
            check("mem_addr_aligned", {30'h0, mem_addr[1:0]}, 32'h0);
            check("mem_addr_range", {31'h0, (mem_addr >= 32'h100 && mem_addr <= 32'h13C)}, 32'h1);
            if (!mem_we) check("mem_be_read", {28'h0, mem_be}, 32'hF);
         end else begin
            check("mem_hold", {31'h0, (mem_addr == hold_addr && mem_be == hold_be &&
                  mem_wdata == hold_wdata && mem_we == hold_we)}, 32'h1);
         end
         if (no_ack || mem_addr == block_addr) begin
            mem_ack = 1'b0;
         end else if (wait_left == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = phys[mem_addr[5:2]];
            if (mem_we) begin
               for (int b = 0; b < 4; b++)
                  if (mem_be[b]) phys[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            end
            pending = 1'b0;
            acks++;
            last_addr = mem_addr; last_be = mem_be; last_wdata = mem_wdata; last_we = mem_we;
         end else begin
            wait_left--;
            mem_ack = 1'b0;
         end
      end else begin
         mem_ack = 1'b0;
         pending = 1'b0;
         if (req_run != 0) last_run = req_run;
         req_run = 0;
      end
   end

   bit hold_rsp = 1'b0;
   always @(posedge clk) begin
      #1;
      rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   // Scoreboard monitor.
   typedef struct { logic [31:0] rdata; logic err; } exp_t;
   exp_t        exp_q[$];
   bit          prev_stall = 1'b0;
   logic [31:0] prev_rdata = 0;
   logic        prev_err = 0;
   int          rsp_count = 0;

   task automatic push_exp(input logic [31:0] d, input logic e);
      exp_t x;
      x.rdata = d;
      x.err   = e;
      exp_q.push_back(x);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            check("rsp_stable", {31'h0, (rsp_valid && rsp_rdata == prev_rdata && rsp_err == prev_err)}, 32'h1);
         if (rsp_valid && rsp_ready) begin
            rsp_count++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got rdata 0x%08h err %0d, required no response", rsp_rdata, rsp_err);
            end else begin
               e = exp_q.pop_front();
               check("rsp_rdata", rsp_rdata, e.rdata);
               check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
               $display("rsp %0d: rdata=0x%08h err=%0d", rsp_count, rsp_rdata, rsp_err);
            end
         end
         prev_stall = rsp_valid && !rsp_ready;
         prev_rdata = rsp_rdata;
         prev_err   = rsp_err;
      end
   end

   task automatic send(input bit w, input logic [1:0] sz, input bit u, input logic [31:0] a,
                       input logic [31:0] wd, input bit wait_rsp, output int lat);
      int guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("req_ready_wait", {31'h0, req_ready}, 32'h1);
      req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      if (wait_rsp) begin
         do begin
            @(negedge clk);
            lat++;
         end while (!rsp_valid && lat < 200);
         check("rsp_wait", {31'h0, rsp_valid}, 32'h1);
      end
   endtask

   task automatic txn(input bit w, input logic [1:0] sz, input bit u, input logic [31:0] a, input logic [31:0] wd);
      int lat, exp_lat;
      int n = 1 << sz;
      int off = int'(a[1:0]);
      bit bad = (n > 4);
      if (bad) push_exp(32'h0, 1'b1);
      else if (w) begin
         push_exp(32'h0, 1'b0);
         ref_store(a, sz, wd, 4);
      end else push_exp(ref_load(a, sz, u), 1'b0);
      send(w, sz, u, a, wd, 1'b1, lat);
      exp_lat = bad ? 1 : ((off + n > 4) ? 3 : 2);
      if (zero_wait) check("latency", lat, exp_lat);
   endtask

   task automatic drain();
      int guard = 0;
      while ((exp_q.size() != 0 || !req_ready) && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      check("drain", exp_q.size(), 32'h0);
   endtask

   int na_req_cycles = 0;
   always @(negedge clk) if (na_mem_req) na_req_cycles++;

   task automatic na_send(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] exp_d,
                          input bit exp_e, input int exp_lat, input int exp_reqs);
      int lat = 0;
      int c0;
      @(negedge clk);
      check("na_ready", {31'h0, na_req_ready}, 32'h1);
      c0 = na_req_cycles;
      na_req_size = sz; na_req_addr = a; na_req_valid = 1'b1;
      @(posedge clk);
      #1 na_req_valid = 1'b0;
      do begin
         @(negedge clk);
         lat++;
      end while (!na_rsp_valid && lat < 50);
      check("na_latency", lat, exp_lat);
      check("na_rdata", na_rsp_rdata, exp_d);
      check("na_err", {31'h0, na_rsp_err}, {31'h0, exp_e});
      check("na_mem_reqs", na_req_cycles - c0, exp_reqs);
      $display("na rsp: addr=0x%08h rdata=0x%08h err=%0d", a, na_rsp_rdata, na_rsp_err);
   endtask

   initial begin
      int lat, a0;
      logic [31:0] w;
      for (int k = 0; k < 16; k++) set_word(32'h100 + 32'(4*k), $urandom);

      // Reset state
      #2;
      check("reset_req_ready", {31'h0, req_ready}, 32'h0);
      check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("reset_mem_req", {31'h0, mem_req}, 32'h0);
      check("reset_mem_be", {28'h0, mem_be}, 32'h0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1 check("post_reset_ready", {31'h0, req_ready}, 32'h1);

      // Aligned LW, zero-wait memory
      zero_wait = 1'b1;
      set_word(32'h100, 32'hDEAD_BEEF);
      push_exp(32'hDEAD_BEEF, 1'b0);
      send(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1, lat);
      check("t1_latency", lat, 2);
      check("t1_mem_addr", last_addr, 32'h100);

      // LB / LBU of 0x80
      set_word(32'h100, 32'h80FF_7F01);
      push_exp(32'hFFFF_FF80, 1'b0);
      send(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1'b1, lat);
      push_exp(32'h0000_0080, 1'b0);
      send(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1'b1, lat);

      // SH at upper half
      a0 = acks;
      push_exp(32'h0, 1'b0);
      ref_store(32'h102, 2'd1, 32'h0000_ABCD, 4);
      send(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_ABCD, 1'b1, lat);
      check("t3_accesses", acks - a0, 1);
      check("t3_mem_be", {28'h0, last_be}, 32'hC);
      check("t3_mem_wdata", last_wdata, 32'hABCD_0000);
      check("t3_mem_we", {31'h0, last_we}, 32'h1);

      // Misaligned LW split over two words
      set_word(32'h104, 32'h4433_2211);
      set_word(32'h108, 32'h8877_6655);
      a0 = acks;
      push_exp(32'h6655_4433, 1'b0);
      send(1'b0, 2'd2, 1'b0, 32'h106, 32'h0, 1'b1, lat);
      check("t4_latency", lat, 3);
      check("t4_accesses", acks - a0, 2);
      check("t4_second_addr", last_addr, 32'h108);
      zero_wait = 1'b0;

      // Timeout with response back-pressure
      drain();
      no_ack = 1'b1;
      hold_rsp = 1'b1;
      push_exp(32'h0, 1'b1);
      send(1'b0, 2'd2, 1'b0, 32'h120, 32'h0, 1'b1, lat);
      check("t5_latency", lat, 17);
      @(posedge clk);
      #1 check("t5_req_cycles", last_run, 16);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t5_hold", {31'h0, (rsp_valid && rsp_err && rsp_rdata == 32'h0)}, 32'h1);
      end
      hold_rsp = 1'b0;
      no_ack = 1'b0;
      drain();

      // Reset during ACC1 of a split store; only the first word is written
      block_addr = 32'h118;
      w = 32'hC0DE_F00D;
      ref_store(32'h116, 2'd2, w, 2);
      send(1'b1, 2'd2, 1'b0, 32'h116, w, 1'b0, lat);
      lat = 0;
      while (!(mem_req && mem_addr == 32'h118) && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("t6_reach_acc1", {31'h0, (mem_req && mem_addr == 32'h118)}, 32'h1);
      #2 reset = 1'b0;
      #1 check("t6_mem_req_async", {31'h0, mem_req}, 32'h0);
      check("t6_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      check("t6_req_ready_in_reset", {31'h0, req_ready}, 32'h0);
      @(negedge clk);
      check("t6_mem_req_held", {31'h0, mem_req}, 32'h0);
      @(negedge clk);
      #2 reset = 1'b1;
      block_addr = 32'hFFFF_FFFF;
      #1 check("t6_req_ready_after", {31'h0, req_ready}, 32'h1);
      check("t6_no_rsp", {31'h0, rsp_valid}, 32'h0);

      // Randomized traffic
      for (int t = 0; t < 150; t++) begin
         logic [1:0] sz;
         zero_wait = ($urandom_range(0, 2) == 0);
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             32'h100 + 32'($urandom_range(0, 56)), $urandom);
      end
      zero_wait = 1'b0;
      drain();

      for (int k = 0; k < 16; k++)
         check("mem_final", phys[k], {ref_mem[4*k+3], ref_mem[4*k+2], ref_mem[4*k+1], ref_mem[4*k]});

      // ALLOW_MISALIGN=0 instance
      na_send(2'd2, 32'h106, 32'h0, 1'b1, 1, 0);
      na_send(2'd2, 32'h100, 32'h1234_5678, 1'b0, 2, 1);
      na_send(2'd0, 32'h103, 32'h0000_0012, 1'b0, 2, 1);
      na_send(2'd1, 32'h103, 32'h0, 1'b1, 1, 0);
      na_send(2'd3, 32'h100, 32'h0, 1'b1, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1, "global timeout");
   end
endmodule
